// File: rtl/hazard_control_unit.sv
// Pipeline stall/flush controller: load-use bubble, EX redirect flush, memory-latency freeze; HAZARD_PERF_CNT_EN adds perf counters.
// Latency: stall/flush outputs are combinational (0 cycles) from inputs, state and sticky response flags.
// Backpressure: an outstanding imem/dmem request without a response freezes all five pipeline stages.
module hazard_control_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] if_id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] if_id_rs2_addr,
    input  logic                  if_id_uses_rs1,
    input  logic                  if_id_uses_rs2,
    input  logic                  id_ex_memread,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  ex_redirect,
    input  logic                  imem_req,
    input  logic                  imem_resp,
    input  logic                  dmem_req,
    input  logic                  dmem_resp,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  stall_ex_mem,
    output logic                  stall_mem_wb,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [CNT_W-1:0]      cnt_freeze,
    output logic [CNT_W-1:0]      cnt_load_use,
    output logic [CNT_W-1:0]      cnt_redirect
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   i_done_q, i_done_d;
    logic   d_done_q, d_done_d;

    logic i_ok;
    logic d_ok;
    logic freeze;
    logic load_use;
    logic take_redirect;
    logic take_load_use;

    // Flags are always clear in RUN, so the same readiness terms serve both states.
    assign i_ok   = !imem_req | imem_resp | i_done_q;
    assign d_ok   = !dmem_req | dmem_resp | d_done_q;
    assign freeze = !(i_ok & d_ok);

    assign load_use = id_ex_memread & (id_ex_rd != '0) &
                      ((if_id_uses_rs1 & (if_id_rs1_addr == id_ex_rd)) |
                       (if_id_uses_rs2 & (if_id_rs2_addr == id_ex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        i_done_d = i_done_q;
        d_done_d = d_done_q;
        if (!freeze) begin
            state_d  = ST_RUN;
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            state_d  = ST_WAIT;
            i_done_d = imem_resp & imem_req;
            d_done_d = dmem_resp & dmem_req;
        end else begin
            i_done_d = i_done_q | imem_resp;
            d_done_d = d_done_q | dmem_resp;
        end
    end

    always_comb begin
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        stall_ex_mem  = 1'b0;
        stall_mem_wb  = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        take_redirect = 1'b0;
        take_load_use = 1'b0;
        if (rst) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (freeze) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            stall_mem_wb = 1'b1;
        end else if (ex_redirect) begin
            // The ID instruction is wrong-path, so a coincident load-use is moot.
            take_redirect = 1'b1;
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
        end else if (load_use) begin
            take_load_use = 1'b1;
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] freeze_cnt_q;
    logic [CNT_W-1:0] load_use_cnt_q;
    logic [CNT_W-1:0] redirect_cnt_q;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            freeze_cnt_q   <= '0;
            load_use_cnt_q <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (freeze)        freeze_cnt_q   <= freeze_cnt_q + CNT_ONE;
            if (take_load_use) load_use_cnt_q <= load_use_cnt_q + CNT_ONE;
            if (take_redirect) redirect_cnt_q <= redirect_cnt_q + CNT_ONE;
        end
    end

    assign cnt_freeze   = freeze_cnt_q;
    assign cnt_load_use = load_use_cnt_q;
    assign cnt_redirect = redirect_cnt_q;
`else
    assign cnt_freeze   = '0;
    assign cnt_load_use = '0;
    assign cnt_redirect = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized plus directed bench for hazard_control_unit against a cycle-level reference model.
module tb_hazard_control_unit;
    localparam int RW = 5;
    localparam int CW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [RW-1:0] rs1, rs2, rd;
    logic          uses1, uses2, memread, redirect;
    logic          ireq, iresp, dreq, dresp;
    logic          stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic          flush_if_id, flush_id_ex;
    logic [CW-1:0] cnt_freeze, cnt_load_use, cnt_redirect;

    hazard_control_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .if_id_rs1_addr(rs1), .if_id_rs2_addr(rs2),
        .if_id_uses_rs1(uses1), .if_id_uses_rs2(uses2),
        .id_ex_memread(memread), .id_ex_rd(rd), .ex_redirect(redirect),
        .imem_req(ireq), .imem_resp(iresp), .dmem_req(dreq), .dmem_resp(dresp),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .cnt_freeze(cnt_freeze), .cnt_load_use(cnt_load_use), .cnt_redirect(cnt_redirect)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: whether a memory wait is in progress and which responses arrived.
    bit          m_waiting, m_i_got, m_d_got;
    int unsigned m_fz, m_lu, m_rd;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int unsigned v);
`ifdef HAZARD_PERF_CNT_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    task automatic step(input string tag, input bit r,
                        input int a1, input int a2, input bit e1, input bit e2,
                        input bit mr, input int d, input bit rdr,
                        input bit ir, input bit irs, input bit dr, input bit drs);
        bit fz, lu, i_ready, d_ready;
        logic [6:0] exp_out, got_out;
        @(negedge clk);
        rst = r; rs1 = RW'(a1); rs2 = RW'(a2); uses1 = e1; uses2 = e2;
        memread = mr; rd = RW'(d); redirect = rdr;
        ireq = ir; iresp = irs; dreq = dr; dresp = drs;
        #1;
        i_ready = !ir || irs || m_i_got;
        d_ready = !dr || drs || m_d_got;
        fz = !(i_ready && d_ready);
        lu = mr && (d != 0) && ((e1 && a1 == d) || (e2 && a2 == d));
        if (r)        exp_out = 7'b00000_11;
        else if (fz)  exp_out = 7'b11111_00;
        else if (rdr) exp_out = 7'b00000_11;
        else if (lu)  exp_out = 7'b11000_01;
        else          exp_out = 7'b00000_00;
        got_out = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, flush_if_id, flush_id_ex};
        check_val({tag, ".out"}, 32'(got_out), 32'(exp_out));
        check_val({tag, ".cnt_freeze"}, cnt_freeze, exp_cnt(m_fz));
        check_val({tag, ".cnt_load_use"}, cnt_load_use, exp_cnt(m_lu));
        check_val({tag, ".cnt_redirect"}, cnt_redirect, exp_cnt(m_rd));
        @(posedge clk);
        if (r) begin
            m_waiting = 0; m_i_got = 0; m_d_got = 0;
            m_fz = 0; m_lu = 0; m_rd = 0;
        end else if (fz) begin
            m_fz++;
            if (!m_waiting) begin
                m_i_got = irs && ir;
                m_d_got = drs && dr;
            end else begin
                m_i_got = m_i_got || irs;
                m_d_got = m_d_got || drs;
            end
            m_waiting = 1;
        end else begin
            m_waiting = 0; m_i_got = 0; m_d_got = 0;
            if (rdr) m_rd++;
            else if (lu) m_lu++;
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; rs1 = '0; rs2 = '0; rd = '0; uses1 = 0; uses2 = 0;
        memread = 0; redirect = 0; ireq = 0; iresp = 0; dreq = 0; dresp = 0;
        m_waiting = 0; m_i_got = 0; m_d_got = 0; m_fz = 0; m_lu = 0; m_rd = 0;

        // Reset with a fetch pending, then release
        step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle("post_rst");

        // Load-use on rs2, bubble cycle, then rd=0 case
        step("lu_hit", 0, 1, 5, 0, 1, 1, 5, 0, 0, 0, 0, 0);
        step("lu_bubble", 0, 1, 5, 0, 1, 0, 5, 0, 0, 0, 0, 0);
        step("lu_x0", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        step("lu_rs1", 0, 7, 3, 1, 0, 1, 7, 0, 0, 0, 0, 0);
        step("lu_unused", 0, 7, 7, 0, 0, 1, 7, 0, 0, 0, 0, 0);

        // Split memory wait: imem response at cycle 1, dmem at cycle 4
        step("split0", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("split1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        step("split2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("split3", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("split4", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        idle("split_done");

        // Redirect together with load-use
        step("redir_lu", 0, 5, 5, 1, 1, 1, 5, 1, 0, 0, 0, 0);
        idle("redir_lu_done");

        // Redirect held across a 3-cycle dmem freeze
        for (int i = 0; i < 3; i++) step("redir_fz", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        step("redir_rel", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        idle("redir_fz_done");

        // Reset pulse during a dmem wait, then re-evaluation
        step("wrst0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("wrst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("wrst2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("wrst3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("wrst4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle("wrst_done");

        // Randomized traffic with small register space to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            step("rand", ($urandom_range(0, 63) == 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end
        idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
